countdown_timer_ctrl: RTL and testbench

//   Controller that sequences a loadable down counter as a programmable countdown timer.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_timer_ctrl_if.sv | 24 ++
 rtl/down_counter_ld.sv | 30 +++
 rtl/countdown_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and sizing helpers for the countdown timer
package countdown_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

    // Prescaler register width; a PRESCALE of 1 still needs a 1-bit register
    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// rtl/countdown_timer_ctrl_if.sv - command/status bundle between control logic and the timer
interface countdown_timer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                              start;
    logic [WIDTH-1:0]                  load_val;
    logic                              auto_reload;
    logic                              pause;
    logic                              abort;
    logic [WIDTH-1:0]                  count;
    logic                              busy;
    logic                              done;
    logic [countdown_pkg::STATE_W-1:0] state_o;

    modport master (
        output start, load_val, auto_reload, pause, abort,
        input  count, busy, done, state_o
    );

    modport slave (
        input  start, load_val, auto_reload, pause, abort,
        output count, busy, done, state_o
    );
endinterface

// File: rtl/down_counter_ld.sv
// rtl/down_counter_ld.sv - loadable down counter with clear, enable-decrement and zero flag
module down_counter_ld #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Clear beats load beats decrement; a decrement at zero is suppressed so the count never wraps
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - countdown timer controller: FSM, prescaler and reload register
module countdown_timer_ctrl
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    countdown_timer_ctrl_if.slave  ctl
);

    localparam int            PW         = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] reload_reg;
    logic             busy_r;
    logic             done_r;

    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] count;
    logic             cnt_zero;

    logic             tick;
    logic             last;
    logic             reload_ok;

    assign tick      = (presc == PRESC_LAST);
    assign last      = (count == WIDTH'(1));
    // A reload of zero would leave RUN with nothing to count, so it falls back to IDLE
    assign reload_ok = ctl.auto_reload && (reload_reg != '0);

    down_counter_ld #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (count),
        .zero     (cnt_zero)
    );

    // Counter commands for this edge, decided from the current state and inputs
    always_comb begin
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = ctl.load_val;
        if (ctl.abort) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        if (ctl.load_val != '0) cnt_load = 1'b1;
                        else                    cnt_clr  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!ctl.pause && tick) cnt_en = 1'b1;
                end
                ST_EXPIRE: begin
                    if (reload_ok) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = reload_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control FSM with prescaler, reload register and registered busy/done
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            presc      <= '0;
            reload_reg <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (ctl.abort) begin
            state  <= ST_IDLE;
            presc  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        busy_r <= 1'b1;
                        if (ctl.load_val != '0) begin
                            reload_reg <= ctl.load_val;
                            presc      <= '0;
                            state      <= ST_RUN;
                        end else begin
                            state  <= ST_EXPIRE;
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (ctl.pause) begin
                        state <= ST_PAUSE;
                    end else if (cnt_zero) begin
                        // Defensive: RUN is never entered with zero, but never count below it
                        state  <= ST_EXPIRE;
                        done_r <= 1'b1;
                    end else if (tick) begin
                        presc <= '0;
                        if (last) begin
                            state  <= ST_EXPIRE;
                            done_r <= 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Prescaler phase is held so resuming continues the partial tick
                    if (!ctl.pause) state <= ST_RUN;
                end
                ST_EXPIRE: begin
                    done_r <= 1'b0;
                    if (reload_ok) begin
                        presc <= '0;
                        state <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ctl.count   = count;
    assign ctl.busy    = busy_r;
    assign ctl.done    = done_r;
    assign ctl.state_o = state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - randomized and directed self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] load_val;
    logic       auto_reload;
    logic       pause;
    logic       abort;

    int errors = 0;
    int checks = 0;

    // Reference model per instance: phase 0=idle 1=counting 2=paused 3=expired
    int m_st  [2];
    int m_cnt [2];
    int m_rel [2];
    int m_ph  [2];
    int presc [2] = '{1, 4};

    always #5 clk = ~clk;

    countdown_timer_ctrl_if #(.WIDTH(4)) bus0 ();
    countdown_timer_ctrl_if #(.WIDTH(4)) bus1 ();

    assign bus0.start       = start;
    assign bus0.load_val    = load_val;
    assign bus0.auto_reload = auto_reload;
    assign bus0.pause       = pause;
    assign bus0.abort       = abort;
    assign bus1.start       = start;
    assign bus1.load_val    = load_val;
    assign bus1.auto_reload = auto_reload;
    assign bus1.pause       = pause;
    assign bus1.abort       = abort;

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus0.slave)
    );

    countdown_timer_ctrl #(.WIDTH(4), .PRESCALE(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of timer behaviour: each tick of PRESCALE cycles removes one unit of time
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_st[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_ph[i] = 0;
            end else if (abort) begin
                m_st[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (start) begin
                        if (load_val != 0) begin
                            m_cnt[i] = load_val; m_rel[i] = load_val; m_ph[i] = 0; m_st[i] = 1;
                        end else begin
                            m_cnt[i] = 0; m_st[i] = 3;
                        end
                    end
                    1: if (pause) begin
                        m_st[i] = 2;
                    end else if (m_ph[i] == presc[i] - 1) begin
                        m_ph[i] = 0;
                        m_cnt[i] = m_cnt[i] - 1;
                        if (m_cnt[i] == 0) m_st[i] = 3;
                    end else begin
                        m_ph[i] = m_ph[i] + 1;
                    end
                    2: if (!pause) m_st[i] = 1;
                    default: if (auto_reload && m_rel[i] != 0) begin
                        m_cnt[i] = m_rel[i]; m_ph[i] = 0; m_st[i] = 1;
                    end else begin
                        m_st[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("count0", bus0.count,   m_cnt[0]);
        check("busy0",  bus0.busy,    m_st[0] != 0);
        check("done0",  bus0.done,    m_st[0] == 3);
        check("state0", bus0.state_o, m_st[0]);
        check("count1", bus1.count,   m_cnt[1]);
        check("busy1",  bus1.busy,    m_st[1] != 0);
        check("done1",  bus1.done,    m_st[1] == 3);
        check("state1", bus1.state_o, m_st[1]);
    endtask

    task automatic do_abort();
        abort = 1'b1; cycle(); abort = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] v);
        start = 1'b1; load_val = v; cycle(); start = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; load_val = '0; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_rel[i] = 0; m_ph[i] = 0;
        end
        cycle(); cycle();
        check("rst_state", bus0.state_o, 0);
        check("rst_busy", bus0.busy, 0);
        reset = 1'b1;

        // Reset in the middle of a count
        do_start(4'd9);
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("midrst_count", bus0.count, 0);
        check("midrst_busy", bus0.busy, 0);
        check("midrst_done", bus0.done, 0);
        check("midrst_state", bus0.state_o, 0);
        cycle();
        reset = 1'b1;

        // Basic countdown 3,2,1,0
        do_start(4'd3);
        check("t2_c3", bus0.count, 3);
        cycle(); check("t2_c2", bus0.count, 2);
        cycle(); check("t2_c1", bus0.count, 1);
        cycle(); check("t2_c0", bus0.count, 0); check("t2_done", bus0.done, 1);
        cycle(); check("t2_busy_off", bus0.busy, 0); check("t2_done_off", bus0.done, 0);
        do_abort();

        // Auto-reload keeps the latched value even when load_val changes
        auto_reload = 1'b1;
        do_start(4'd2);
        load_val = 4'd7;
        check("t3_c2", bus0.count, 2);
        cycle(); check("t3_c1", bus0.count, 1);
        cycle(); check("t3_done_a", bus0.done, 1);
        cycle(); check("t3_reload", bus0.count, 2);
        cycle(); cycle(); check("t3_done_b", bus0.done, 1);
        auto_reload = 1'b0;
        cycle(); check("t3_idle", bus0.state_o, 0);
        do_abort();

        // Pause holds count and state
        do_start(4'd5);
        cycle(); cycle();
        check("t4_c3", bus0.count, 3);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_hold", bus0.count, 3);
            check("t4_pstate", bus0.state_o, 2);
        end
        pause = 1'b0;
        cycle(); cycle(); check("t4_c2", bus0.count, 2);
        cycle(); cycle(); check("t4_done", bus0.done, 1);
        cycle();
        do_abort();

        // Abort, start while busy, zero load
        do_start(4'd5);
        cycle(); cycle(); cycle();
        check("t5_c2", bus0.count, 2);
        abort = 1'b1; cycle(); abort = 1'b0;
        check("t5_abort_state", bus0.state_o, 0);
        check("t5_abort_count", bus0.count, 0);
        check("t5_abort_done", bus0.done, 0);
        do_start(4'd4);
        do_start(4'd9);
        check("t5_ignored", bus0.count, 3);
        do_abort();
        do_start(4'd0);
        check("t5_zero_done", bus0.done, 1);
        cycle();
        check("t5_zero_idle", bus0.state_o, 0);
        do_abort();

        // PRESCALE=4 latency and full-range load
        do_start(4'd2);
        n = 0;
        while (bus1.done !== 1'b1 && n < 100) begin cycle(); n++; end
        check("t6_lat8", n, 8);
        cycle(); cycle();
        do_start(4'd15);
        check("t6_load15", bus1.count, 15);
        n = 0;
        while (bus1.done !== 1'b1 && n < 100) begin cycle(); n++; end
        check("t6_lat60", n, 60);
        cycle();

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            start       = ($urandom % 4) == 0;
            load_val    = 4'($urandom);
            auto_reload = ($urandom % 3) == 0;
            if (($urandom % 8) == 0) pause = ~pause;
            abort       = ($urandom % 50) == 0;
            reset       = ($urandom % 300) != 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
